// File: rtl/vco_freq_counter.sv
// Gated edge counter giving a clk-referenced VCO frequency readout.
// Define VCO_FREQ_CONT_EN to chain measurements back-to-back after a single start.
module vco_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_BASE   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vco_in,
  input  logic             start,
  input  logic [1:0]       gate_sel,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  // state  | meaning
  // IDLE   | waiting for start
  // ARM    | clear edge counter and flag, load gate timer
  // GATE   | count synchronised rising edges for the gate window
  // DONE   | result presented, done pulse high
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_GATE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int TMR_W = $clog2(GATE_BASE) + 4;

  logic [1:0]             state;
  logic [1:0]             sel_q;
  logic [TMR_W-1:0]       timer;
  logic [TMR_W-1:0]       gate_len;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   sat;
  logic                   sat_nxt;
  logic                   cnt_max;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vco_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign gate_len = TMR_W'(GATE_BASE) << sel_q;
  assign cnt_max  = &edge_cnt;
  assign cnt_nxt  = (rise && !cnt_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign sat_nxt  = sat | (rise & cnt_max);

  // Results are registered on the last gate cycle (including its rise) so the
  // DONE cycle already presents count/valid/overflow alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sel_q    <= 2'd0;
      timer    <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sel_q <= gate_sel;
            busy  <= 1'b1;
            state <= S_ARM;
          end
        end
        S_ARM: begin
          edge_cnt <= '0;
          sat      <= 1'b0;
          timer    <= gate_len - TMR_W'(1);
          state    <= S_GATE;
        end
        S_GATE: begin
          edge_cnt <= cnt_nxt;
          sat      <= sat_nxt;
          if (timer == '0) begin
            count    <= cnt_nxt;
            overflow <= sat_nxt;
            valid    <= 1'b1;
            done     <= 1'b1;
`ifndef VCO_FREQ_CONT_EN
            busy     <= 1'b0;
`endif
            state    <= S_DONE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_DONE: begin
`ifdef VCO_FREQ_CONT_EN
          state <= S_ARM;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_freq_counter.sv
// Scoreboard bench for vco_freq_counter: expected edge-count ranges come from
// window length / VCO period; a monitor pops and checks on every done pulse.
module tb_vco_freq_counter;
  localparam int CNT_W     = 7;
  localparam int GATE_BASE = 64;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             vco_in;
  logic             start;
  logic [1:0]       gate_sel;
  logic             busy;
  logic             done;
  logic             valid;
  logic             overflow;
  logic [CNT_W-1:0] count;

  typedef struct {
    int lo;
    int hi;
    int ovf;       // 0/1 required, 2 = either (window straddles saturation)
    int done_cyc;
    int busy_len;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vco_per = 0;
  int   vco_hi = 0;

  vco_freq_counter #(.CNT_W(CNT_W), .GATE_BASE(GATE_BASE), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .vco_in(vco_in), .start(start), .gate_sel(gate_sel),
    .busy(busy), .done(done), .valid(valid), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // VCO source: periodic square wave, or held low when vco_per == 0
  initial begin
    int ph;
    ph = 0;
    vco_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (vco_per == 0) begin
        vco_in = 1'b0;
        ph = 0;
      end else begin
        vco_in = (ph < vco_hi);
        ph = (ph + 1 >= vco_per) ? 0 : ph + 1;
      end
    end
  end

  // Monitor: pops one expectation per done pulse, checks hold between results
  initial begin
    exp_t e;
    int   busy_run;
    int   last_count;
    int   last_ovf;
    bit   have_last;
    busy_run = 0;
    have_last = 1'b0;
    last_count = 0;
    last_ovf = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
        have_last = 1'b0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1'b0, 1, 0);
          end else begin
            e = sbq.pop_front();
            checks++;
            if (int'(count) < e.lo || int'(count) > e.hi) begin
              errors++;
              $display("FAIL count: got %0d, expected %0d..%0d (cycle %0d)", count, e.lo, e.hi, cyc);
            end
            if (e.ovf != 2) chk("overflow", int'(overflow) == e.ovf, int'(overflow), e.ovf);
            chk("valid_at_done", valid == 1'b1, int'(valid), 1);
            chk("done_cycle", cyc == e.done_cyc, cyc, e.done_cyc);
`ifndef VCO_FREQ_CONT_EN
            chk("busy_length", busy_run == e.busy_len, busy_run, e.busy_len);
`endif
          end
          last_count = int'(count);
          last_ovf = int'(overflow);
          have_last = 1'b1;
          busy_run = 0;
        end else if (busy && have_last) begin
          chk("count_hold", int'(count) == last_count, int'(count), last_count);
          chk("ovf_hold", int'(overflow) == last_ovf, int'(overflow), last_ovf);
          chk("valid_hold", valid == 1'b1, int'(valid), 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_vco(input int per, input int hi);
    vco_per = per;
    vco_hi = hi;
    tick(2 * per + 8);
  endtask

  // Reference: N consecutive cycles of a period-P wave hold floor or ceil(N/P) edges
  task automatic push_exp(input int n, input int done_at);
    exp_t e;
    int   lo;
    int   hi;
    if (vco_per == 0) begin
      lo = 0;
      hi = 0;
    end else begin
      lo = n / vco_per;
      hi = (n + vco_per - 1) / vco_per;
    end
    e.ovf = (lo > MAXC) ? 1 : ((hi <= MAXC) ? 0 : 2);
    e.lo = (lo > MAXC) ? MAXC : lo;
    e.hi = (hi > MAXC) ? MAXC : hi;
    e.done_cyc = done_at;
    e.busy_len = n + 1;
    sbq.push_back(e);
  endtask

  task automatic issue_start(input int sel);
    int n;
    n = GATE_BASE << sel;
    gate_sel = 2'(sel);
    start = 1'b1;
    push_exp(n, cyc + 2 + n);
    tick(1);
    start = 1'b0;
    gate_sel = 2'($urandom);
  endtask

  task automatic measure(input int sel);
    issue_start(sel);
    tick((GATE_BASE << sel) + 6);
    chk("missing_done", sbq.size() == 0, sbq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    gate_sel = 2'd0;
    tick(3);
    rst = 1'b0;
    chk("rst_busy", busy == 1'b0, int'(busy), 0);
    chk("rst_done", done == 1'b0, int'(done), 0);
    chk("rst_valid", valid == 1'b0, int'(valid), 0);
    chk("rst_overflow", overflow == 1'b0, int'(overflow), 0);
    chk("rst_count", count == '0, int'(count), 0);

`ifdef VCO_FREQ_CONT_EN
    begin
      int n;
      int t0;
      int drops;
      n = GATE_BASE;
      set_vco(8, 4);
      gate_sel = 2'd0;
      start = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 4; i++) push_exp(n, t0 + 2 + n + i * (n + 2));
      tick(1);
      start = 1'b0;
      drops = 0;
      for (int i = 0; i < 3 * (n + 2) + n + 3; i++) begin
        if (i == 100) start = 1'b1;
        if (i == 101) start = 1'b0;
        if (!busy) drops++;
        tick(1);
      end
      chk("busy_continuous", drops == 0, drops, 0);
      chk("missing_done", sbq.size() == 0, sbq.size(), 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2 * (n + 2));
      chk("busy_after_rst", busy == 1'b0, int'(busy), 0);
    end
`else
    set_vco(8, 4);
    measure(0);
    measure(3);

    // reset in the middle of a gate window discards the measurement
    issue_start(2);
    tick(99);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sbq.delete();
    chk("midrst_busy", busy == 1'b0, int'(busy), 0);
    chk("midrst_valid", valid == 1'b0, int'(valid), 0);
    chk("midrst_count", count == '0, int'(count), 0);
    chk("midrst_overflow", overflow == 1'b0, int'(overflow), 0);
    chk("midrst_done", done == 1'b0, int'(done), 0);
    tick(300);
    measure(0);

    // starts during ARM/GATE/DONE are ignored
    begin
      int t0;
      int n;
      n = GATE_BASE << 1;
      t0 = cyc;
      issue_start(1);
      tick(4);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(44);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(t0 + 2 + n - cyc);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(20);
      chk("busy_after_ignored", busy == 1'b0, int'(busy), 0);
      chk("missing_done", sbq.size() == 0, sbq.size(), 0);
    end

    // saturation then a clean zero-count run
    set_vco(3, 1);
    measure(3);
    set_vco(0, 0);
    measure(0);

    for (int i = 0; i < 12; i++) begin
      int per;
      if ($urandom_range(0, 5) == 0) begin
        set_vco(0, 0);
      end else begin
        per = int'($urandom_range(3, 24));
        set_vco(per, int'($urandom_range(1, per - 1)));
      end
      measure(int'($urandom_range(0, 3)));
    end
`endif

    chk("queue_empty", sbq.size() == 0, sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
